// File: rtl/conv_out_serializer.sv
// Captures a binarized convolution output frame on the rising edge of img_done
// and streams it out LSB-first as WORD_W-bit words over a valid/ready interface.
module conv_out_serializer #(
  parameter int IMG_SIZE = 28,
  parameter int WORD_W   = 8
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [IMG_SIZE*IMG_SIZE-1:0] img_in,
  input  logic                         img_done,
  output logic [WORD_W-1:0]            m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         m_last,
  output logic                         busy,
  output logic                         overflow,
  output logic [15:0]                  frame_cnt
);

  localparam int N      = IMG_SIZE * IMG_SIZE;
  localparam int NWORDS = (N + WORD_W - 1) / WORD_W;
  localparam int PADW   = NWORDS * WORD_W;
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state;
  logic              done_q;
  logic [IDX_W-1:0]  word_idx;
  logic [IDX_W-1:0]  next_idx;
  logic [WORD_W-1:0] shadow   [NWORDS];
  logic [WORD_W-1:0] in_words [NWORDS];
  logic [PADW-1:0]   img_pad;
  logic              capture;
  logic              handshake;
  logic              final_hs;

  // Zero-extending to whole words makes the unused tail of the last word read as 0.
  assign img_pad = PADW'(img_in);

  always_comb begin
    for (int w = 0; w < NWORDS; w++) begin
      in_words[w] = img_pad[w*WORD_W +: WORD_W];
    end
  end

  assign capture   = img_done & ~done_q;
  assign handshake = (state == SEND) & m_valid & m_ready;
  assign final_hs  = handshake & (word_idx == LAST_IDX);
  assign next_idx  = word_idx + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (rstn) begin
      state     <= IDLE;
      done_q    <= 1'b0;
      word_idx  <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
      frame_cnt <= '0;
      for (int w = 0; w < NWORDS; w++) begin
        shadow[w] <= '0;
      end
    end else begin
      done_q <= img_done;

      if (final_hs) begin
        frame_cnt <= frame_cnt + 16'd1;
      end

      // A frame arriving mid-stream cannot be buffered; only the final-word edge frees the buffer.
      if (capture && (state == SEND) && !final_hs) begin
        overflow <= 1'b1;
      end

      if (capture && ((state == IDLE) || final_hs)) begin
        for (int w = 0; w < NWORDS; w++) begin
          shadow[w] <= in_words[w];
        end
        state    <= SEND;
        word_idx <= '0;
        m_data   <= in_words[0];
        m_valid  <= 1'b1;
        m_last   <= (LAST_IDX == '0);
        busy     <= 1'b1;
      end else if (final_hs) begin
        state    <= IDLE;
        word_idx <= '0;
        m_data   <= '0;
        m_valid  <= 1'b0;
        m_last   <= 1'b0;
        busy     <= 1'b0;
      end else if (handshake) begin
        word_idx <= next_idx;
        m_data   <= shadow[next_idx];
        m_last   <= (next_idx == LAST_IDX);
      end
    end
  end

endmodule

// File: tb/tb_conv_out_serializer.sv
// Scoreboard bench for conv_out_serializer with a 5x5 image and 8-bit words
// (25 pixels -> 4 words per frame).
module tb_conv_out_serializer;

  localparam int IMG_SIZE = 5;
  localparam int WORD_W   = 8;
  localparam int N        = IMG_SIZE * IMG_SIZE;

  logic              clk;
  logic              rstn;
  logic [N-1:0]      img_in;
  logic              img_done;
  logic [WORD_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic              busy;
  logic              overflow;
  logic [15:0]       frame_cnt;

  int errors = 0;
  int checks = 0;
  int hs_count = 0;

  // Each entry is {last, data}.
  logic [WORD_W:0] exp_q [$];

  conv_out_serializer #(
    .IMG_SIZE(IMG_SIZE),
    .WORD_W  (WORD_W)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .img_in   (img_in),
    .img_done (img_done),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last),
    .busy     (busy),
    .overflow (overflow),
    .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: pops on every handshake and checks stall stability against the queue head.
  always @(negedge clk) begin
    if (!rstn && m_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_word: got data 0x%0h last %0b, expected no word", m_data, m_last);
      end else if (m_ready) begin
        check_output("word_data", 32'(m_data), 32'(exp_q[0][WORD_W-1:0]));
        check_output("word_last", 32'(m_last), 32'(exp_q[0][WORD_W]));
        void'(exp_q.pop_front());
        hs_count++;
      end else begin
        check_output("stall_data", 32'(m_data), 32'(exp_q[0][WORD_W-1:0]));
        check_output("stall_last", 32'(m_last), 32'(exp_q[0][WORD_W]));
      end
    end
  end

  task automatic push_frame(input logic [N-1:0] img);
    logic [31:0] padded;
    padded = 32'(img);
    for (int w = 0; w < 4; w++) begin
      exp_q.push_back({(w == 3), padded[w*8 +: 8]});
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    rstn     = 1'b1;
    img_done = 1'b0;
    m_ready  = 1'b0;
    img_in   = '0;
    next_cycle();
    next_cycle();
    exp_q.delete();
    rstn = 1'b0;
  endtask

  // Raises img_done; the capturing edge is the next rising clock edge.
  task automatic apply_stimulus(input logic [N-1:0] img);
    next_cycle();
    img_in   = img;
    img_done = 1'b1;
    push_frame(img);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (m_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (m_valid) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: m_valid still 1 after %0d cycles, expected 0", name, budget);
    end
    check_output({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    #1;
  endtask

  localparam logic [N-1:0] IMG_A = 25'h1_AA_55_F0;
  localparam logic [N-1:0] IMG_B = 25'h0_00_00_01;
  localparam logic [N-1:0] IMG_C = 25'h0_FF_FF_FF;

  initial begin
    logic [6:0] ready_pat;
    int hs_start;
    rstn     = 1'b1;
    img_done = 1'b0;
    m_ready  = 1'b0;
    img_in   = '0;

    // Reset state while reset is held
    next_cycle();
    next_cycle();
    check_output("reset_valid", 32'(m_valid), 32'd0);
    check_output("reset_data", 32'(m_data), 32'd0);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_frame_cnt", 32'(frame_cnt), 32'd0);

    // 1: basic frame, m_ready always high
    do_reset();
    m_ready = 1'b1;
    apply_stimulus(IMG_A);
    next_cycle();
    img_done = 1'b0;
    check_output("t1_valid_c1", 32'(m_valid), 32'd1);
    check_output("t1_busy_c1", 32'(busy), 32'd1);
    wait_idle("t1", 20);
    check_output("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    check_output("t1_busy_end", 32'(busy), 32'd0);
    check_output("t1_overflow", 32'(overflow), 32'd0);

    // 2: backpressure pattern 1,0,0,1,0,1,1
    do_reset();
    hs_start = hs_count;
    ready_pat = 7'b1101001;
    apply_stimulus(IMG_A);
    for (int i = 0; i < 7; i++) begin
      next_cycle();
      img_done = 1'b0;
      m_ready  = ready_pat[i];
    end
    m_ready = 1'b1;
    wait_idle("t2", 20);
    check_output("t2_handshakes", 32'(hs_count - hs_start), 32'd4);
    check_output("t2_frame_cnt", 32'(frame_cnt), 32'd1);

    // 3: second frame arrives during word 1 and is dropped
    do_reset();
    m_ready = 1'b1;
    apply_stimulus(IMG_A);
    next_cycle();
    img_done = 1'b0;
    next_cycle();
    img_in   = IMG_C;
    img_done = 1'b1;
    next_cycle();
    img_done = 1'b0;
    wait_idle("t3", 20);
    check_output("t3_overflow", 32'(overflow), 32'd1);
    check_output("t3_frame_cnt", 32'(frame_cnt), 32'd1);
    repeat (5) next_cycle();
    check_output("t3_overflow_sticky", 32'(overflow), 32'd1);

    // 4: second frame lands on the final-word handshake edge
    do_reset();
    m_ready = 1'b1;
    apply_stimulus(IMG_A);
    next_cycle();
    img_done = 1'b0;
    next_cycle();
    next_cycle();
    next_cycle();
    img_in   = IMG_B;
    img_done = 1'b1;
    push_frame(IMG_B);
    next_cycle();
    img_done = 1'b0;
    check_output("t4_no_bubble", 32'(m_valid), 32'd1);
    check_output("t4_frame_cnt_mid", 32'(frame_cnt), 32'd1);
    wait_idle("t4", 20);
    check_output("t4_frame_cnt", 32'(frame_cnt), 32'd2);
    check_output("t4_overflow", 32'(overflow), 32'd0);

    // 5: img_done held high long after the frame finishes
    do_reset();
    m_ready = 1'b1;
    apply_stimulus(IMG_A);
    repeat (24) next_cycle();
    check_output("t5_valid", 32'(m_valid), 32'd0);
    check_output("t5_frame_cnt", 32'(frame_cnt), 32'd1);
    check_output("t5_queue_left", 32'(exp_q.size()), 32'd0);
    img_done = 1'b0;

    // 6: reset after the second word, then a fresh frame
    do_reset();
    m_ready = 1'b1;
    apply_stimulus(IMG_A);
    next_cycle();
    img_done = 1'b0;
    next_cycle();
    next_cycle();
    rstn = 1'b1;
    exp_q.delete();
    next_cycle();
    check_output("t6_valid", 32'(m_valid), 32'd0);
    check_output("t6_data", 32'(m_data), 32'd0);
    check_output("t6_last", 32'(m_last), 32'd0);
    check_output("t6_busy", 32'(busy), 32'd0);
    check_output("t6_frame_cnt", 32'(frame_cnt), 32'd0);
    rstn = 1'b0;
    apply_stimulus(IMG_A);
    next_cycle();
    img_done = 1'b0;
    wait_idle("t6", 20);
    check_output("t6_frame_cnt_end", 32'(frame_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
